// File: rtl/clock_set_controller.sv
// Mode/setting sequencer for the digital clock.
// Turns debounced MODE/INC levels into mode state, increment pulses and timeout.
module clock_set_controller #(
    parameter int unsigned HOLD_CYC    = 25_000_000,
    parameter int unsigned REP_CYC     = 10_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       halt,
    output logic [1:0] field,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } state_e;

    localparam int unsigned HR_MAX =
        (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int HW = $clog2(HR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REP_M1  = HW'(REP_CYC - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic          mode_prev_q, inc_prev_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic          arm_q, arm_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          inc_hour_q, inc_hour_d;
    logic          inc_min_q, inc_min_d;
    logic          clr_sec_q, clr_sec_d;

    logic mode_press, inc_press, inc_pulse, act;

    assign mode_press = mode_btn & ~mode_prev_q;
    assign inc_press  = inc_btn & ~inc_prev_q;

    assign halt     = (state_q != RUN);
    assign field    = state_q;
    assign inc_hour = inc_hour_q;
    assign inc_min  = inc_min_q;
    assign clr_sec  = clr_sec_q;

    // State, counters, edge-detect history and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            hold_q      <= '0;
            rep_q       <= 1'b0;
            arm_q       <= 1'b0;
            idle_q      <= '0;
            inc_hour_q  <= 1'b0;
            inc_min_q   <= 1'b0;
            clr_sec_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            arm_q       <= arm_d;
            idle_q      <= idle_d;
            inc_hour_q  <= inc_hour_d;
            inc_min_q   <= inc_min_d;
            clr_sec_q   <= clr_sec_d;
        end
    end

    // Next mode, hold/repeat timing, idle timeout and pulse generation.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        arm_d     = arm_q;
        idle_d    = idle_q;
        clr_sec_d = 1'b0;
        inc_pulse = 1'b0;
        act       = 1'b0;

        if (state_q == RUN) begin
            hold_d = '0;
            rep_d  = 1'b0;
            arm_d  = 1'b0;
            idle_d = '0;
            if (mode_press) begin
                state_d = SET_H;
            end
        end else begin
            if (mode_press) begin
                act       = 1'b1;
                hold_d    = '0;
                rep_d     = 1'b0;
                arm_d     = 1'b0;
                clr_sec_d = (state_q == SET_M);
                state_d   = (state_q == SET_H) ? SET_M : RUN;
            end else if (inc_press) begin
                act       = 1'b1;
                inc_pulse = 1'b1;
                hold_d    = '0;
                rep_d     = 1'b0;
                arm_d     = 1'b1;
            end else if (arm_q && inc_btn) begin
                if (rep_q ? (hold_q == REP_M1) : (hold_q == HOLD_M1)) begin
                    act       = 1'b1;
                    inc_pulse = 1'b1;
                    hold_d    = '0;
                    rep_d     = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end else begin
                // Released (or held from before a mode change): stop repeating.
                hold_d = '0;
                rep_d  = 1'b0;
                arm_d  = 1'b0;
            end

            if (act) begin
                idle_d = '0;
            end else if (idle_q == TO_M1) begin
                state_d = RUN;
                idle_d  = '0;
                hold_d  = '0;
                rep_d   = 1'b0;
                arm_d   = 1'b0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end

        inc_hour_d = inc_pulse && (state_q == SET_H);
        inc_min_d  = inc_pulse && (state_q == SET_M);
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: timestamp-based model checked every cycle,
// plus directed literal checks for each scenario.
module tb_clock_set_controller;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int TOUT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       halt;
    logic [1:0] field;
    logic       inc_hour, inc_min, clr_sec;

    int tests = 0;
    int fails = 0;

    clock_set_controller #(
        .HOLD_CYC(HOLD),
        .REP_CYC(REP),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_btn(mode_btn),
        .inc_btn(inc_btn),
        .halt(halt),
        .field(field),
        .inc_hour(inc_hour),
        .inc_min(inc_min),
        .clr_sec(clr_sec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, got, exp);
        end
    endtask

    // Model: mode 0=RUN 1=SET_H 2=SET_M; timing from timestamps.
    int n       = 0;
    int m_mode  = 0;
    bit m_pm    = 1'b1;
    bit m_pi    = 1'b1;
    bit m_armed = 1'b0;
    int t_press = 0;
    int t_act   = 0;
    bit e_ih    = 1'b0;
    bit e_im    = 1'b0;
    bit e_cs    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pm = 1; m_pi = 1; m_armed = 0;
            e_ih = 0; e_im = 0; e_cs = 0;
        end else begin
            bit mp, ip, busy;
            int d;
            n++;
            mp = mode_btn && !m_pm;
            ip = inc_btn && !m_pi;
            m_pm = mode_btn;
            m_pi = inc_btn;
            e_ih = 0; e_im = 0; e_cs = 0;
            busy = 0;
            if (m_mode == 0) begin
                m_armed = 0;
                if (mp) m_mode = 1;
            end else if (mp) begin
                e_cs = (m_mode == 2);
                m_mode = (m_mode + 1) % 3;
                m_armed = 0;
                t_act = n;
            end else begin
                if (ip) begin
                    m_armed = 1;
                    t_press = n;
                    busy = 1;
                end else if (m_armed && inc_btn) begin
                    d = n - t_press;
                    if (d >= HOLD && (d - HOLD) % REP == 0) busy = 1;
                end else begin
                    m_armed = 0;
                end
                if (busy) begin
                    t_act = n;
                    if (m_mode == 1) e_ih = 1;
                    else e_im = 1;
                end else if (n - t_act == TOUT) begin
                    m_mode = 0;
                    m_armed = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("field", int'(field), m_mode);
            chk("halt", int'(halt), int'(m_mode != 0));
            chk("inc_hour", int'(inc_hour), int'(e_ih));
            chk("inc_min", int'(inc_min), int'(e_im));
            chk("clr_sec", int'(clr_sec), int'(e_cs));
            chk("onehot", int'(inc_hour) + int'(inc_min) + int'(clr_sec) <= 1, 1);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    int cnt;
    int pos[$];
    int exp_pos[7] = '{1, 9, 13, 17, 21, 25, 29};
    int first0;

    initial begin
        // 1: reset release, idle
        tick(3);
        rst = 1'b0;
        chk("t1_field", int'(field), 0);
        chk("t1_halt", int'(halt), 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            cnt += int'(inc_hour) + int'(inc_min) + int'(clr_sec);
        end
        chk("t1_pulses", cnt, 0);

        // 2: mode cycling
        mode_btn = 1; tick(1);
        chk("t2_f1", int'(field), 1);
        chk("t2_h1", int'(halt), 1);
        tick(1); mode_btn = 0; tick(5);
        mode_btn = 1; tick(1);
        chk("t2_f2", int'(field), 2);
        chk("t2_cs_early", int'(clr_sec), 0);
        tick(1); mode_btn = 0; tick(5);
        mode_btn = 1; tick(1);
        chk("t2_f0", int'(field), 0);
        chk("t2_h0", int'(halt), 0);
        chk("t2_cs", int'(clr_sec), 1);
        tick(1);
        chk("t2_cs_once", int'(clr_sec), 0);
        mode_btn = 0; tick(5);

        // 3: hold-to-repeat in SET_H
        mode_btn = 1; tick(2); mode_btn = 0; tick(3);
        inc_btn = 1;
        pos.delete();
        cnt = 0;
        for (int i = 1; i <= 34; i++) begin
            tick(1);
            if (inc_hour) pos.push_back(i);
            cnt += int'(inc_min);
            if (i == 30) inc_btn = 0;
        end
        chk("t3_count", pos.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("t3_pos", (i < pos.size()) ? pos[i] : -1, exp_pos[i]);
        chk("t3_min", cnt, 0);

        // 4: timeout from SET_M, then INC ignored in RUN
        mode_btn = 1;
        first0 = -1;
        cnt = 0;
        for (int i = 1; i <= 34; i++) begin
            tick(1);
            if (i == 2) mode_btn = 0;
            if (i == 32) chk("t4_f32", int'(field), 2);
            if (first0 < 0 && field == 2'b00) first0 = i;
            cnt += int'(clr_sec);
        end
        chk("t4_first0", first0, 33);
        chk("t4_cs", cnt, 0);
        inc_btn = 1; tick(3); inc_btn = 0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            cnt += int'(inc_hour) + int'(inc_min);
        end
        chk("t4_run_inc", cnt, 0);

        // 5: simultaneous mode+inc, then held INC gives nothing
        mode_btn = 1; tick(2); mode_btn = 0; tick(2);
        mode_btn = 1; inc_btn = 1; tick(1);
        chk("t5_field", int'(field), 2);
        cnt = int'(inc_hour) + int'(inc_min);
        tick(1); mode_btn = 0;
        for (int i = 0; i < 18; i++) begin
            tick(1);
            cnt += int'(inc_hour) + int'(inc_min);
        end
        chk("t5_nopulse", cnt, 0);
        inc_btn = 0; tick(2);
        inc_btn = 1; tick(1);
        chk("t5_repress", int'(inc_min), 1);
        tick(7);
        chk("t5_rep8", int'(inc_min), 0);
        tick(1);
        chk("t5_rep9", int'(inc_min), 1);
        inc_btn = 0; tick(3);
        mode_btn = 1; tick(2); mode_btn = 0; tick(2);
        chk("t5_run", int'(field), 0);

        // 6: mode held through reset, then reset mid auto-repeat
        rst = 1; mode_btn = 1; tick(2);
        rst = 0; tick(5);
        chk("t6_held", int'(field), 0);
        mode_btn = 0; tick(2);
        mode_btn = 1; tick(1);
        chk("t6_repress", int'(field), 1);
        tick(1); mode_btn = 0; tick(2);
        mode_btn = 1; tick(1); mode_btn = 0; tick(2);
        chk("t6_setm", int'(field), 2);
        inc_btn = 1;
        tick(13);
        chk("t6_rep", int'(inc_min), 1);
        rst = 1;
        #1;
        chk("t6_rst_min", int'(inc_min), 0);
        chk("t6_rst_field", int'(field), 0);
        chk("t6_rst_halt", int'(halt), 0);
        tick(2);
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            cnt += int'(inc_hour) + int'(inc_min) + int'(clr_sec);
        end
        chk("t6_stray", cnt, 0);
        chk("t6_field", int'(field), 0);
        inc_btn = 0; tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
